audio_score_feeder: RTL and testbench
=====================================

# audio_score_feeder

Producer side of the keyword post-processing stream. On a start pulse from the CNN engine it fetches the NUM_CLASS class scores from the result memory, tolerating arbitration stalls. It then replays them to the post-processor as one init pulse followed by one gap-free burst of write strobes. The burst is gap-free because the post-processor closes a frame on the falling edge of its write strobe: any gap would end the frame early.

## Interface
Parameters:
- NUM_CLASS, 7: scores per frame; 1..7, because index 7 is reserved as invalid downstream
- ADDR_W, 10: result-memory address width
- BASE_ADDR, 0: address of score 0; score k is at BASE_ADDR+k

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; every register clears immediately
- i_start  in  1  one-cycle frame request; honored only in IDLE
- i_gnt  in  1  memory grant; a read may be issued only in a cycle where it is high
- o_rd_en  out  1  read strobe; combinational: FILL & i_gnt & (issued < NUM_CLASS)
- o_rd_addr  out  ADDR_W  BASE_ADDR + issued count
- i_rd_data  in  16  read data, valid exactly one cycle after o_rd_en
- o_init  out  1  one-cycle frame-clear pulse to the post-processor
- o_we  out  1  score strobe; high for exactly NUM_CLASS consecutive cycles per frame
- o_dout  out  16  score k on the k-th o_we cycle; two's complement, passed unmodified
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse in the cycle after the last o_we

## Operation
- States: IDLE → FILL → INIT → BURST → DONE → IDLE.
- IDLE
  - i_start moves the FSM to FILL.
  - The issue counter and return counter are cleared.
  - i_start in any other state is ignored: no queueing, no error flag.
- FILL
  - Each cycle in which o_rd_en is high increments the issue counter.
  - A registered copy of o_rd_en writes i_rd_data into buf[return count] and increments the return counter.
  - When i_gnt is low, no read is issued and the counters hold; gaps from stalls go only into the buffer.
  - FILL exits to INIT when the return counter reaches NUM_CLASS.
- INIT: o_init is high for one cycle; the next state is BURST.
- BURST
  - o_we is high and o_dout = buf[k] for k = 0..NUM_CLASS-1, one per cycle, with no gaps.
  - i_gnt is ignored; o_rd_en is 0.
- DONE: o_done is high for one cycle; the next state is IDLE, where a new i_start is accepted.
- Arithmetic
  - Counters are 3 bits.
  - o_rd_addr = BASE_ADDR + zero-extended issue count, truncated to ADDR_W. Wrap past 2^ADDR_W-1 is legal and silent.
- Data integrity
  - Buffer contents are not cleared between frames.
  - Each frame overwrites all NUM_CLASS entries before any entry is read.
- Reset mid-frame
  - All outputs go to 0 and the FSM goes to IDLE.
  - No o_init, o_we or o_done is emitted for the aborted frame.
  - A read still in flight when reset deasserts is discarded.

## Timing
- Reset values: o_rd_en 0, o_rd_addr BASE_ADDR, o_init 0, o_we 0, o_dout 0, o_busy 0, o_done 0.
- o_init, o_we, o_dout, o_busy and o_done are registered. o_rd_en and o_rd_addr are combinational from state and counters.
- With i_start in cycle 0 and i_gnt held high:
  - o_rd_en is high in cycles 1..NUM_CLASS
  - o_init is high in cycle NUM_CLASS+2
  - o_we is high in cycles NUM_CLASS+3 .. 2·NUM_CLASS+2
  - o_done is high in cycle 2·NUM_CLASS+3
- Each cycle with i_gnt low during FILL shifts every later event by one cycle.
- o_dout holds its last value after a burst; it is don't-care while o_we is low.

## Structure
- Shared package:
  - state encoding (IDLE, FILL, INIT, BURST, DONE)
  - default NUM_CLASS = 7
  - score width = 16
  - invalid class index 3'b111, also used by the post-processor
- One sub-module, audio_score_buf: an NUM_CLASS×16 register file with one write port (we, waddr, wdata) and one registered read port. The FSM and counters stay in audio_score_feeder.

## Test plan
- Memory holds 0..6 = {10, -3, 500, 20, 499, 0, 7}; i_start with i_gnt held high:
  - o_rd_addr 0..6 in cycles 1..7
  - o_init in cycle 9
  - o_we in cycles 10..16 with o_dout in that order
  - o_done in cycle 17
  - with the post-processor attached: max index 2, diff 1
- i_gnt low in cycles 3..5 of FILL: o_rd_en gaps, o_init in cycle 12, o_we still 7 contiguous cycles (13..19), same data.
- i_start pulsed again during FILL and again during BURST: ignored, exactly one o_init/o_we burst/o_done per frame.
- reset asserted in the 3rd BURST cycle: all outputs are 0 in the same cycle, no o_done; a new i_start then gives a complete, correct frame.
- BASE_ADDR = 1020, ADDR_W = 10: o_rd_addr = 1020, 1021, 1022, 1023, 0, 1, 2.
- Back-to-back frames (i_start in the cycle after o_done) with a different data set: no stale buffer data appears on o_dout.

Source files
------------

// File: rtl/audio_score_feeder_pkg.sv
// audio_score_feeder_pkg: shared encodings and widths for the score feeder (rev 1.0)
`default_nettype none

package audio_score_feeder_pkg;

  localparam int NUM_CLASS_DEF = 7;
  localparam int SCORE_W       = 16;
  localparam int CNT_W         = 3;

  // Class index 7 is never a valid score slot; the post-processor uses it as "none".
  localparam logic [CNT_W-1:0] INVALID_IDX = 3'b111;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FILL  = 3'd1;
  localparam state_t S_INIT  = 3'd2;
  localparam state_t S_BURST = 3'd3;
  localparam state_t S_DONE  = 3'd4;

endpackage

`default_nettype wire

// File: rtl/audio_score_buf.sv
// audio_score_buf: NUM_CLASS x SCORE_W register file, one write port, one registered read port (rev 1.0)
`default_nettype none

module audio_score_buf
  import audio_score_feeder_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we_i,
  input  logic [CNT_W-1:0]   waddr_i,
  input  logic [SCORE_W-1:0] wdata_i,
  input  logic               re_i,
  input  logic [CNT_W-1:0]   raddr_i,
  output logic [SCORE_W-1:0] rdata_o
);

  localparam logic [CNT_W-1:0] NC = CNT_W'(NUM_CLASS);

  logic [SCORE_W-1:0] mem_q [NUM_CLASS];
  logic [SCORE_W-1:0] rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CLASS; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i && (waddr_i < NC)) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // Read register only moves on a request, so the last score stays on the bus.
      if (re_i && (raddr_i < NC)) begin
        rdata_q <= mem_q[raddr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/audio_score_feeder.sv
// audio_score_feeder: fetches NUM_CLASS scores under arbitration stalls, replays them as init + gap-free burst (rev 1.0)
`default_nettype none

module audio_score_feeder
  import audio_score_feeder_pkg::*;
#(
  parameter int NUM_CLASS = NUM_CLASS_DEF,
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_gnt,
  output logic               o_rd_en,
  output logic [ADDR_W-1:0]  o_rd_addr,
  input  logic [SCORE_W-1:0] i_rd_data,
  output logic               o_init,
  output logic               o_we,
  output logic [SCORE_W-1:0] o_dout,
  output logic               o_busy,
  output logic               o_done
);

  localparam logic [CNT_W-1:0] NC   = CNT_W'(NUM_CLASS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_CLASS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iss_q, iss_d;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             rd_en_q;
  logic             init_q, init_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             busy_q;
  logic             buf_re;
  logic [CNT_W-1:0] buf_raddr;

  assign o_rd_en   = (state_q == S_FILL) && i_gnt && (iss_q < NC);
  assign o_rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(iss_q);

  always_comb begin
    state_d   = state_q;
    iss_d     = iss_q;
    ret_d     = ret_q;
    idx_d     = idx_q;
    init_d    = 1'b0;
    we_d      = 1'b0;
    done_d    = 1'b0;
    buf_re    = 1'b0;
    buf_raddr = idx_q;
    case (state_q)
      S_IDLE: begin
        iss_d = '0;
        ret_d = '0;
        idx_d = '0;
        if (i_start) state_d = S_FILL;
      end
      S_FILL: begin
        if (o_rd_en) iss_d = iss_q + 1'b1;
        // Leaving on the last return lets o_init land the cycle after the final write.
        if (rd_en_q) begin
          ret_d = ret_q + 1'b1;
          if (ret_q == LAST) begin
            state_d = S_INIT;
            init_d  = 1'b1;
          end
        end
      end
      S_INIT: begin
        state_d   = S_BURST;
        buf_re    = 1'b1;
        buf_raddr = '0;
        we_d      = 1'b1;
        idx_d     = 3'd1;
      end
      S_BURST: begin
        if (idx_q < NC) begin
          buf_re = 1'b1;
          we_d   = 1'b1;
          idx_d  = idx_q + 1'b1;
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      iss_q   <= '0;
      ret_q   <= '0;
      idx_q   <= '0;
      rd_en_q <= 1'b0;
      init_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      iss_q   <= iss_d;
      ret_q   <= ret_d;
      idx_q   <= idx_d;
      rd_en_q <= o_rd_en;
      init_q  <= init_d;
      we_q    <= we_d;
      done_q  <= done_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  audio_score_buf #(
    .NUM_CLASS (NUM_CLASS)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .we_i    (rd_en_q),
    .waddr_i (ret_q),
    .wdata_i (i_rd_data),
    .re_i    (buf_re),
    .raddr_i (buf_raddr),
    .rdata_o (o_dout)
  );

  assign o_init = init_q;
  assign o_we   = we_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_score_feeder.sv
// tb_audio_score_feeder: directed self-checking bench for the score feeder (rev 1.0)
`default_nettype none

module tb_audio_score_feeder;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic        i_gnt;
  logic        o_rd_en;
  logic [9:0]  o_rd_addr;
  logic [15:0] rd_data;
  logic        o_init;
  logic        o_we;
  logic [15:0] o_dout;
  logic        o_busy;
  logic        o_done;

  logic        o_rd_en2;
  logic [9:0]  o_rd_addr2;
  logic        o_init2;
  logic        o_we2;
  logic [15:0] o_dout2;
  logic        o_busy2;
  logic        o_done2;

  logic [15:0] mem [1024];

  int checks = 0;
  int errors = 0;

  int rd_n, rd_first, rd_last, rd2_n;
  int init_n, init_cyc, we_n, we_first, we_last, done_n, done_cyc;
  logic [9:0]  addr_log  [16];
  logic [9:0]  addr2_log [16];
  logic [15:0] dout_log  [16];

  logic [15:0] set_a [7] = '{16'd10, 16'hFFFD, 16'd500, 16'd20, 16'd499, 16'd0, 16'd7};
  logic [15:0] set_b [7] = '{16'd1000, 16'h8000, 16'd1, 16'h7FFF, 16'd42, 16'hFFFF, 16'd3};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (o_rd_en) rd_data <= mem[o_rd_addr];
  end

  audio_score_feeder #(
    .NUM_CLASS (7),
    .ADDR_W    (10),
    .BASE_ADDR (0)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_gnt     (i_gnt),
    .o_rd_en   (o_rd_en),
    .o_rd_addr (o_rd_addr),
    .i_rd_data (rd_data),
    .o_init    (o_init),
    .o_we      (o_we),
    .o_dout    (o_dout),
    .o_busy    (o_busy),
    .o_done    (o_done)
  );

  audio_score_feeder #(
    .NUM_CLASS (7),
    .ADDR_W    (10),
    .BASE_ADDR (1020)
  ) u_dut_hi (
    .clk       (clk),
    .reset     (reset),
    .i_start   (i_start),
    .i_gnt     (i_gnt),
    .o_rd_en   (o_rd_en2),
    .o_rd_addr (o_rd_addr2),
    .i_rd_data (16'h0000),
    .o_init    (o_init2),
    .o_we      (o_we2),
    .o_dout    (o_dout2),
    .o_busy    (o_busy2),
    .o_done    (o_done2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the cycle i_start is high; events are logged by cycle number.
  task automatic frame(input logic [63:0] gnt_low, input logic [63:0] restart);
    rd_n = 0; rd_first = -1; rd_last = -1; rd2_n = 0;
    init_n = 0; init_cyc = -1; we_n = 0; we_first = -1; we_last = -1;
    done_n = 0; done_cyc = -1;
    i_start = 1'b1;
    i_gnt   = ~gnt_low[0];
    for (int c = 1; c < 48; c++) begin
      @(posedge clk);
      #1;
      i_start = restart[c];
      i_gnt   = ~gnt_low[c];
      #1;
      if (o_rd_en) begin
        if (rd_n < 16) addr_log[rd_n] = o_rd_addr;
        if (rd_n == 0) rd_first = c;
        rd_last = c;
        rd_n++;
      end
      if (o_rd_en2 && rd2_n < 16) begin
        addr2_log[rd2_n] = o_rd_addr2;
        rd2_n++;
      end
      if (o_init) begin
        init_n++;
        init_cyc = c;
      end
      if (o_we) begin
        if (we_n < 16) dout_log[we_n] = o_dout;
        if (we_n == 0) we_first = c;
        we_last = c;
        we_n++;
      end
      if (o_done) begin
        done_n++;
        done_cyc = c;
        break;
      end
    end
    i_start = 1'b0;
    i_gnt   = 1'b1;
  endtask

  task automatic check_frame(input string t, input logic [15:0] exp [7], input int e_init);
    chk({t, ".rd_count"}, rd_n, 7);
    chk({t, ".init_count"}, init_n, 1);
    chk({t, ".init_cycle"}, init_cyc, e_init);
    chk({t, ".we_count"}, we_n, 7);
    chk({t, ".we_first"}, we_first, e_init + 1);
    chk({t, ".we_last"}, we_last, e_init + 7);
    chk({t, ".done_count"}, done_n, 1);
    chk({t, ".done_cycle"}, done_cyc, e_init + 8);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("%s.dout%0d", t, k), dout_log[k], exp[k]);
    end
  endtask

  task automatic quiet(input string t, input int n);
    int ev_init, ev_we, ev_done;
    ev_init = 0; ev_we = 0; ev_done = 0;
    for (int c = 0; c < n; c++) begin
      step();
      if (o_init) ev_init++;
      if (o_we)   ev_we++;
      if (o_done) ev_done++;
    end
    chk({t, ".extra_init"}, ev_init, 0);
    chk({t, ".extra_we"}, ev_we, 0);
    chk({t, ".extra_done"}, ev_done, 0);
  endtask

  initial begin
    int best, second, diff;
    reset   = 1'b1;
    i_start = 1'b0;
    i_gnt   = 1'b1;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 7; i++) mem[i] = set_a[i];
    step();
    step();

    chk("rst.rd_en", o_rd_en, 0);
    chk("rst.rd_addr", o_rd_addr, 0);
    chk("rst.init", o_init, 0);
    chk("rst.we", o_we, 0);
    chk("rst.dout", o_dout, 0);
    chk("rst.busy", o_busy, 0);
    chk("rst.done", o_done, 0);
    chk("rst.hi_rd_addr", o_rd_addr2, 1020);
    reset = 1'b0;
    step();

    // Nominal frame, grant held high
    frame(64'h0, 64'h0);
    check_frame("nom", set_a, 9);
    chk("nom.rd_first", rd_first, 1);
    chk("nom.rd_last", rd_last, 7);
    for (int k = 0; k < 7; k++) chk($sformatf("nom.addr%0d", k), addr_log[k], k);
    chk("hi.rd_count", rd2_n, 7);
    chk("hi.addr0", addr2_log[0], 1020);
    chk("hi.addr1", addr2_log[1], 1021);
    chk("hi.addr2", addr2_log[2], 1022);
    chk("hi.addr3", addr2_log[3], 1023);
    chk("hi.addr4", addr2_log[4], 0);
    chk("hi.addr5", addr2_log[5], 1);
    chk("hi.addr6", addr2_log[6], 2);
    best = 0;
    for (int k = 1; k < 7; k++)
      if ($signed(dout_log[k]) > $signed(dout_log[best])) best = k;
    second = (best == 0) ? 1 : 0;
    for (int k = 0; k < 7; k++)
      if (k != best && $signed(dout_log[k]) > $signed(dout_log[second])) second = k;
    diff = int'($signed(dout_log[best])) - int'($signed(dout_log[second]));
    chk("nom.max_idx", best, 2);
    chk("nom.max_diff", diff, 1);
    step();
    step();

    // Grant low in cycles 3..5 of the fetch
    frame(64'h38, 64'h0);
    check_frame("stall", set_a, 12);
    chk("stall.rd_first", rd_first, 1);
    chk("stall.rd_last", rd_last, 10);
    for (int k = 0; k < 7; k++) chk($sformatf("stall.addr%0d", k), addr_log[k], k);
    step();
    step();

    // Extra start pulses during FILL (cycle 3) and BURST (cycle 12)
    frame(64'h0, (64'h1 << 3) | (64'h1 << 12));
    check_frame("restart", set_a, 9);
    quiet("restart", 12);

    // Reset in the third burst cycle
    i_start = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      i_start = 1'b0;
    end
    chk("mid.we_before", o_we, 1);
    chk("mid.dout_before", o_dout, set_a[2]);
    reset = 1'b1;
    #1;
    chk("mid.rd_en", o_rd_en, 0);
    chk("mid.rd_addr", o_rd_addr, 0);
    chk("mid.init", o_init, 0);
    chk("mid.we", o_we, 0);
    chk("mid.dout", o_dout, 0);
    chk("mid.busy", o_busy, 0);
    chk("mid.done", o_done, 0);
    step();
    reset = 1'b0;
    quiet("post_rst", 20);
    frame(64'h0, 64'h0);
    check_frame("after_rst", set_a, 9);

    // Back-to-back: new data, start in the cycle after o_done
    for (int i = 0; i < 7; i++) mem[i] = set_b[i];
    step();
    frame(64'h0, 64'h0);
    check_frame("b2b", set_b, 9);
    step();
    chk("end.busy", o_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
